mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 42 ++++
 rtl/mem_timer.sv | 105 ++++++++++
 rtl/mem_responder.sv | 91 +++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared address map, register offsets and region decode for the memory responder.
package mem_responder_pkg;

    localparam logic [19:0] RAM_BASE   = 20'h00000;
    localparam logic [19:0] TIMER_BASE = 20'h72000;
    localparam logic [19:0] PAR_BASE   = 20'h73000;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_TIMER,
        REGION_PAR,
        REGION_NONE
    } region_e;

    typedef enum logic [1:0] {
        TMR_CTRL   = 2'd0,
        TMR_LOAD   = 2'd1,
        TMR_COUNT  = 2'd2,
        TMR_STATUS = 2'd3
    } tmr_reg_e;

    typedef enum logic [1:0] {
        PAR_SWITCHES = 2'd0,
        PAR_RSVD1    = 2'd1,
        PAR_LEDS     = 2'd2,
        PAR_RSVD3    = 2'd3
    } par_reg_e;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_AUTO_BIT = 1;
    localparam int unsigned STAT_IRQ_BIT  = 0;
    localparam int unsigned STAT_OVR_BIT  = 1;

    function automatic region_e decode_region(input logic [19:0] addr,
                                              input int unsigned ram_words);
        if (32'(addr - RAM_BASE) < ram_words) return REGION_RAM;
        if (addr[19:2] == TIMER_BASE[19:2])   return REGION_TIMER;
        if (addr[19:2] == PAR_BASE[19:2])     return REGION_PAR;
        return REGION_NONE;
    endfunction

endpackage

// File: rtl/mem_timer.sv
// Prescaled 16-bit down-counting timer with one-shot/auto-restart modes,
// sticky interrupt and overrun status.
module mem_timer
    import mem_responder_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sel_i,
    input  logic        we_i,
    input  tmr_reg_e    reg_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    logic [1:0]  ctrl_q,   ctrl_d;
    logic [15:0] load_q,   load_d;
    logic [15:0] count_q,  count_d;
    logic [1:0]  status_q, status_d;
    logic [15:0] presc_q,  presc_d;

    logic       tick;
    logic       terminal;
    logic [1:0] evt_set;

    always_comb begin
        tick     = ctrl_q[CTRL_EN_BIT] && (presc_q == PRESC_MAX);
        terminal = tick && (count_q == '0);
        evt_set  = '0;
        evt_set[STAT_IRQ_BIT] = terminal;
        evt_set[STAT_OVR_BIT] = terminal && status_q[STAT_IRQ_BIT];

        ctrl_d   = ctrl_q;
        load_d   = load_q;
        count_d  = count_q;
        status_d = status_q | evt_set;
        presc_d  = presc_q;

        if (ctrl_q[CTRL_EN_BIT]) begin
            presc_d = tick ? '0 : 16'(presc_q + 16'd1);
        end

        if (tick) begin
            if (count_q != '0) begin
                count_d = 16'(count_q - 16'd1);
            end else if (ctrl_q[CTRL_AUTO_BIT]) begin
                count_d = load_q;
            end else begin
                ctrl_d[CTRL_EN_BIT] = 1'b0;
            end
        end

        // CPU writes are applied last so they override the timer's own update,
        // except that event-set status bits survive a written zero.
        if (sel_i && we_i) begin
            case (reg_i)
                TMR_CTRL: begin
                    ctrl_d  = wdata_i[1:0];
                    presc_d = '0;
                end
                TMR_LOAD: begin
                    load_d  = wdata_i;
                    count_d = wdata_i;
                end
                TMR_COUNT:  count_d  = wdata_i;
                TMR_STATUS: status_d = wdata_i[1:0] | evt_set;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_o = '0;
        case (reg_i)
            TMR_CTRL:   rdata_o = {30'b0, ctrl_q};
            TMR_LOAD:   rdata_o = {16'b0, load_q};
            TMR_COUNT:  rdata_o = {16'b0, count_q};
            TMR_STATUS: rdata_o = {30'b0, status_q};
            default:    rdata_o = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q   <= '0;
            load_q   <= '0;
            count_q  <= '0;
            status_q <= '0;
            presc_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            load_q   <= load_d;
            count_q  <= count_d;
            status_q <= status_d;
            presc_q  <= presc_d;
        end
    end

    assign irq_o = status_q[STAT_IRQ_BIT];

endmodule

// File: rtl/mem_responder.sv
// CPU-facing memory responder: RAM, timer and parallel I/O behind a
// word-addressed bus with registered, read-before-write read data.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 16384,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic        clk,
    input  logic        rst_async,
    input  logic [19:0] mem_address,
    input  logic        mem_write_en,
    input  logic [31:0] mem_write_value,
    output logic [31:0] mem_read_value,
    input  logic [15:0] switches,
    output logic [15:0] leds,
    output logic        timer_irq
);

    localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [31:0]       ram_q [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    region_e           region;
    par_reg_e          par_reg;

    logic [31:0] rdata_q, rdata_d;
    logic [15:0] leds_q,  leds_d;
    logic [31:0] tmr_rdata;

    assign region  = decode_region(mem_address, RAM_WORDS);
    assign ram_idx = mem_address[RAM_AW-1:0];
    assign par_reg = par_reg_e'(mem_address[1:0]);

    mem_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk_i   (clk),
        .rst_ni  (rst_async),
        .sel_i   (region == REGION_TIMER),
        .we_i    (mem_write_en),
        .reg_i   (tmr_reg_e'(mem_address[1:0])),
        .wdata_i (mem_write_value[15:0]),
        .rdata_o (tmr_rdata),
        .irq_o   (timer_irq)
    );

    // RAM deliberately has no reset so it can map onto block memory.
    always_ff @(posedge clk) begin
        if (mem_write_en && region == REGION_RAM) begin
            ram_q[ram_idx] <= mem_write_value;
        end
    end

    always_comb begin
        rdata_d = '0;
        case (region)
            REGION_RAM:   rdata_d = ram_q[ram_idx];
            REGION_TIMER: rdata_d = tmr_rdata;
            REGION_PAR: begin
                case (par_reg)
                    PAR_SWITCHES: rdata_d = {16'b0, switches};
                    PAR_LEDS:     rdata_d = {16'b0, leds_q};
                    default:      rdata_d = '0;
                endcase
            end
            default: rdata_d = '0;
        endcase
    end

    always_comb begin
        leds_d = leds_q;
        if (mem_write_en && region == REGION_PAR && par_reg == PAR_LEDS) begin
            leds_d = mem_write_value[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            rdata_q <= '0;
            leds_q  <= '0;
        end else begin
            rdata_q <= rdata_d;
            leds_q  <= leds_d;
        end
    end

    assign mem_read_value = rdata_q;
    assign leds           = leds_q;

endmodule
